// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin, packet-locked arbiter sharing one UART TX FIFO write port
// Optional mid-packet idle release: define UART_ARB_TIMEOUT_EN
module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 3,
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   i_req_valid,
   input  logic [8*NUM_REQ-1:0] i_req_data,
   input  logic [NUM_REQ-1:0]   i_req_last,
   output logic [NUM_REQ-1:0]   o_req_ready,
   output logic                 o_fifo_wr_en,
   output logic [7:0]           o_fifo_din,
   input  logic                 i_fifo_full,
   input  logic                 i_fifo_almost_full,
   output logic                 o_busy,
   output logic [IDX_W-1:0]     o_grant_idx,
   output logic [CNT_W-1:0]     o_byte_cnt,
   output logic [CNT_W-1:0]     o_pkt_cnt,
   output logic                 o_timeout_err
);

   typedef enum logic {S_IDLE, S_BUSY} state_t;

   state_t             r_state;
   state_t             w_next;
   logic [IDX_W-1:0]   r_grant_idx;
   logic               r_wr_en;
   logic [7:0]         r_din;
   logic [CNT_W-1:0]   r_byte_cnt;
   logic [CNT_W-1:0]   r_pkt_cnt;

   logic [NUM_REQ-1:0] w_own;
   logic               w_own_valid;
   logic               w_own_last;
   logic [7:0]         w_own_data;
   logic               w_room;
   logic               w_accept;
   logic [IDX_W-1:0]   w_pick;
   logic               w_timeout;

   always_comb begin
      w_own      = '0;
      w_own_data = 8'h00;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_own[i] = (r_grant_idx == IDX_W'(i));
         if (w_own[i]) w_own_data = i_req_data[8*i +: 8];
      end
      w_own_valid = |(i_req_valid & w_own);
      w_own_last  = |(i_req_last & w_own);
   end

   // A write still in flight consumes the last free slot when almost_full is set.
   assign w_room = ~i_fifo_full & ~(r_wr_en & i_fifo_almost_full);

   // Scan from farthest to nearest so the nearest valid lane after the pointer wins.
   always_comb begin
      w_pick = r_grant_idx;
      for (int k = NUM_REQ; k >= 1; k--) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (i_req_valid[i] && ((int'(r_grant_idx) + k) % NUM_REQ) == i) w_pick = IDX_W'(i);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      o_req_ready = '0;
      w_accept    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (|i_req_valid) w_next = S_BUSY;
         end
         S_BUSY: begin
            o_req_ready = w_room ? w_own : '0;
            w_accept    = w_own_valid & w_room;
            if (w_accept & w_own_last) w_next = S_IDLE;
            else if (w_timeout)        w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant_idx <= IDX_W'(NUM_REQ - 1);
         r_wr_en     <= 1'b0;
         r_din       <= 8'h00;
         r_byte_cnt  <= '0;
         r_pkt_cnt   <= '0;
      end else begin
         if (r_state == S_IDLE && |i_req_valid) r_grant_idx <= w_pick;
         r_wr_en <= w_accept;
         if (w_accept) begin
            r_din      <= w_own_data;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            if (w_own_last) r_pkt_cnt <= r_pkt_cnt + 1'b1;
         end
      end
   end

`ifdef UART_ARB_TIMEOUT_EN
   logic [7:0] r_idle_cnt;
   logic       r_timeout_err;

   // Only owner silence counts; FIFO back-pressure never advances the counter.
   assign w_timeout = (r_state == S_BUSY) & ~w_own_valid & (r_idle_cnt == 8'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_idle_cnt    <= 8'h00;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= w_timeout;
         if (r_state != S_BUSY || w_accept) r_idle_cnt <= 8'h00;
         else if (!w_own_valid)             r_idle_cnt <= r_idle_cnt + 8'h01;
      end
   end

   assign o_timeout_err = r_timeout_err;
`else
   assign w_timeout     = 1'b0;
   assign o_timeout_err = 1'b0;
`endif

   assign o_fifo_wr_en = r_wr_en;
   assign o_fifo_din   = r_din;
   assign o_busy       = (r_state == S_BUSY);
   assign o_grant_idx  = r_grant_idx;
   assign o_byte_cnt   = r_byte_cnt;
   assign o_pkt_cnt    = r_pkt_cnt;

endmodule
